nx_wrr_arb: RTL and testbench



---
 rtl/nx_wrr_arb_pkg.sv | 8 +
 rtl/nx_wrr_arb_rr_pick.sv | 30 +++
 rtl/nx_wrr_arb.sv | 78 +++++++
 tb/tb_nx_wrr_arb.sv | 122 ++++++++++++
 4 files changed

// File: rtl/nx_wrr_arb_pkg.sv
// nx_arb_pkg: shared FSM type, stats counter width and weight helper for nx_wrr_arb
package nx_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;
  localparam int ARB_CNT_W = 16;
  function automatic logic [31:0] wgt_eff(input logic [31:0] w);
    return (w == '0) ? 32'd1 : w;
  endfunction
endpackage

// File: rtl/nx_wrr_arb_rr_pick.sv
// nx_rr_pick: combinational pick of first req after last (wrapping); excl_idx is skipped unless it is the only requester; outputs vld, idx
module nx_rr_pick #(
  parameter int N = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  input  logic             excl_en,
  input  logic [IDX_W-1:0] excl_idx,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);
  logic [N-1:0] ex, rest, req_m;
  int j;
  assign ex = excl_en ? N'(1) << excl_idx : '0;
  assign rest = req & ~ex;
  assign req_m = (|rest) ? rest : req;
  always_comb begin
    vld = 1'b0;
    idx = '0;
    j = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last) + k) % N;
      if (req_m[j]) begin
        vld = 1'b1;
        idx = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/nx_wrr_arb.sv
// nx_wrr_arb: registered weighted round-robin arbiter (clk, rst_n, enable, req, weight, advance -> grant, grant_vld, grant_idx; NX_WRR_ARB_STATS_EN adds stats_clr -> grant_cnt)
module nx_wrr_arb
  import nx_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int WGT_W = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [N-1:0]           req,
  input  logic [N*WGT_W-1:0]     weight,
  input  logic                   advance,
`ifdef NX_WRR_ARB_STATS_EN
  input  logic                   stats_clr,
  output logic [N*ARB_CNT_W-1:0] grant_cnt,
`endif
  output logic [N-1:0]           grant,
  output logic                   grant_vld,
  output logic [IDX_W-1:0]       grant_idx
);
  arb_state_e state;
  logic [IDX_W-1:0] last_r, pick_idx;
  logic [WGT_W-1:0] beat_cnt;
  logic [N-1:0][WGT_W-1:0] wgt;
  logic [WGT_W:0] eff;
  logic burst, wgt_done, eob, pick_vld, issue;
  assign wgt = weight;
  assign burst = state == ARB_BURST;
  assign eff = (WGT_W+1)'(wgt_eff(32'(wgt[grant_idx])));
  // one extra bit so a full-scale weight never wraps the compare
  assign wgt_done = advance && ({1'b0, beat_cnt} + (WGT_W+1)'(1) >= eff);
  assign eob = burst && (!req[grant_idx] || wgt_done);
  assign issue = enable && pick_vld && (!burst || eob);
  assign grant_vld = |grant;
  // at end-of-burst the pointer is already the grantee, so the same picker serves both cases
  nx_rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req      (req),
    .last     (burst ? grant_idx : last_r),
    .excl_en  (burst && wgt_done),
    .excl_idx (grant_idx),
    .vld      (pick_vld),
    .idx      (pick_idx)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      last_r <= IDX_W'(N-1);
      beat_cnt <= '0;
      grant <= '0;
      grant_idx <= '0;
    end else begin
      if (eob) last_r <= grant_idx;
      if (issue) begin
        state <= ARB_BURST;
        grant <= N'(1) << pick_idx;
        grant_idx <= pick_idx;
        beat_cnt <= '0;
      end else if (eob) begin
        state <= ARB_IDLE;
        grant <= '0;
        grant_idx <= '0;
        beat_cnt <= '0;
      end else if (burst && advance) begin
        beat_cnt <= beat_cnt + WGT_W'(1);
      end
    end
  end
`ifdef NX_WRR_ARB_STATS_EN
  logic [N-1:0][ARB_CNT_W-1:0] cnt;
  assign grant_cnt = cnt;
  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) cnt <= '0;
    else if (issue && cnt[pick_idx] != '1) cnt[pick_idx] <= cnt[pick_idx] + ARB_CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_nx_wrr_arb.sv
// tb_nx_wrr_arb: table-driven directed bench for nx_wrr_arb
module tb_nx_wrr_arb;
  logic clk = 0, rst_n = 0, enable = 0, advance = 0;
  logic [7:0] req = '0;
  logic [31:0] weight = '0;
  logic [7:0] grant;
  logic grant_vld;
  logic [2:0] grant_idx;
  int checks = 0, errors = 0;
`ifdef NX_WRR_ARB_STATS_EN
  logic stats_clr = 0;
  logic [127:0] grant_cnt;
`endif
  nx_wrr_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req       (req),
    .weight    (weight),
    .advance   (advance),
`ifdef NX_WRR_ARB_STATS_EN
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt),
`endif
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r, e, a;
    logic [7:0] q;
    logic [31:0] w;
    logic [7:0] g;
    logic [2:0] i;
  } vec_t;
  vec_t v[$];
  function automatic void add(logic r, logic e, logic a, logic [7:0] q, logic [31:0] w, logic [7:0] g, logic [2:0] i);
    v.push_back('{r, e, a, q, w, g, i});
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic step(logic r, logic e, logic a, logic [7:0] q, logic [31:0] w);
    rst_n = r;
    enable = e;
    advance = a;
    req = q;
    weight = w;
    @(posedge clk);
    #1;
  endtask
  localparam logic [31:0] W1 = 32'h1111_1111;
  initial begin
    add(0, 0, 0, 8'h00, W1, 8'h00, 0);
    add(1, 1, 1, 8'h81, W1, 8'h01, 0);
    add(1, 1, 1, 8'h81, W1, 8'h80, 7);
    add(1, 1, 1, 8'h81, W1, 8'h01, 0);
    add(1, 1, 1, 8'h81, W1, 8'h80, 7);
    add(0, 0, 0, 8'h00, 32'h130, 8'h00, 0);
    for (int k = 0; k < 2; k++) begin
      add(1, 1, 1, 8'h06, 32'h130, 8'h02, 1);
      add(1, 1, 1, 8'h06, 32'h130, 8'h02, 1);
      add(1, 1, 1, 8'h06, 32'h130, 8'h02, 1);
      add(1, 1, 1, 8'h06, 32'h130, 8'h04, 2);
    end
    add(0, 0, 0, 8'h00, 32'h0, 8'h00, 0);
    for (int k = 0; k < 4; k++) add(1, 1, 1, 8'h08, 32'h0, 8'h08, 3);
    add(1, 1, 0, 8'h08, 32'h0, 8'h08, 3);
    add(0, 0, 0, 8'h00, 32'h14, 8'h00, 0);
    add(1, 1, 1, 8'h03, 32'h14, 8'h01, 0);
    add(1, 1, 1, 8'h03, 32'h14, 8'h01, 0);
    add(1, 1, 1, 8'h03, 32'h14, 8'h01, 0);
    add(1, 0, 1, 8'h03, 32'h14, 8'h01, 0);
    add(1, 0, 1, 8'h03, 32'h14, 8'h00, 0);
    add(1, 0, 1, 8'h03, 32'h14, 8'h00, 0);
    add(1, 1, 0, 8'h03, 32'h14, 8'h02, 1);
    add(0, 0, 0, 8'h00, 32'h0040_0000, 8'h00, 0);
    add(1, 1, 0, 8'h20, 32'h0040_0000, 8'h20, 5);
    add(1, 1, 1, 8'h20, 32'h0040_0000, 8'h20, 5);
    add(1, 1, 0, 8'h00, 32'h0040_0000, 8'h00, 0);
    add(1, 1, 0, 8'h41, 32'h0040_0000, 8'h40, 6);
    add(0, 0, 0, 8'h00, W1, 8'h00, 0);
    add(1, 1, 1, 8'h10, W1, 8'h10, 4);
    add(1, 1, 1, 8'h10, W1, 8'h10, 4);
    add(0, 1, 1, 8'hFF, W1, 8'h00, 0);
    add(1, 1, 0, 8'hFF, W1, 8'h01, 0);
    add(0, 0, 0, 8'h00, W1, 8'h00, 0);
    add(1, 0, 1, 8'h01, W1, 8'h00, 0);
    add(1, 1, 0, 8'h01, W1, 8'h01, 0);
    foreach (v[k]) begin
      step(v[k].r, v[k].e, v[k].a, v[k].q, v[k].w);
      chk($sformatf("row%0d grant", k), 32'(grant), 32'(v[k].g));
      chk($sformatf("row%0d grant_idx", k), 32'(grant_idx), 32'(v[k].i));
      chk($sformatf("row%0d grant_vld", k), 32'(grant_vld), 32'(v[k].g != 0));
    end
    step(0, 0, 0, 8'h00, 32'h1F);
    for (int k = 0; k < 15; k++) begin
      step(1, 1, 1, 8'h03, 32'h1F);
      chk($sformatf("w15 beat%0d grant", k), 32'(grant), 32'h01);
    end
    step(1, 1, 1, 8'h03, 32'h1F);
    chk("w15 rotate grant", 32'(grant), 32'h02);
`ifdef NX_WRR_ARB_STATS_EN
    step(0, 0, 0, 8'h00, W1);
    chk("stats reset", grant_cnt[31:0], 32'h0);
    for (int k = 0; k < 65540; k++) step(1, 1, 1, 8'h01, W1);
    chk("stats sat idx0", 32'(grant_cnt[15:0]), 32'hFFFF);
    chk("stats idx1", 32'(grant_cnt[31:16]), 32'h0);
    stats_clr = 1;
    step(1, 0, 0, 8'h00, W1);
    stats_clr = 0;
    chk("stats clr", 32'(grant_cnt[15:0]), 32'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
